// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI datapath.
//   state_e      - master FSM states
//   shift_mode_e - shift-register operation select (tx/rx shifters)
//   DEFAULT_WIDTH - default bits per transfer
package spi_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEAD = 3'd1,
        HIGH = 3'd2,
        LOW  = 3'd3,
        DONE = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        PLOAD = 2'd3
    } shift_mode_e;

endpackage

// File: rtl/spi_clkgen.sv
// spi_clkgen: half-period counter for the SPI master.
//   clk, rst_n  - clock, synchronous active-low reset
//   en          - count while high
//   clear       - synchronous restart to zero (wins over en)
//   phase_tick  - one-cycle pulse on the last cycle of every CLK_DIV-cycle phase
module spi_clkgen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clear,
    output logic phase_tick
);

    localparam int unsigned   CW   = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    // Counter wraps only at the phase boundary, so phases stay aligned.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

    // Combinational so the FSM leaves a phase exactly on its final cycle.
    assign phase_tick = en && (count == LAST);

endmodule

// File: rtl/spi_master_byte.sv
// spi_master_byte: mode-0 (CPOL=0, CPHA=0) SPI master, MSB first.
//   start/tx_data  - transfer request and byte to send (taken in IDLE)
//   busy           - high from the cycle after acceptance through done
//   done/rx_data   - one-cycle completion pulse and received byte
//   sclk/cs_n/mosi - serial outputs; miso - serial input (clk-synchronous)
// Optional: define SPI_MASTER_BURST_EN to accept a new start in the DONE
// cycle and keep cs_n low across back-to-back transfers.
module spi_master_byte
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data,
    output logic             sclk,
    output logic             cs_n,
    output logic             mosi,
    input  logic             miso
);

    localparam int unsigned BCW = $clog2(WIDTH + 1);

    state_e           state;
    state_e           next_state;
    logic             accept;
    logic             phase_tick;
    logic             cnt_en;
    logic             cnt_clear;
    logic [BCW-1:0]   bit_cnt;
    logic [WIDTH-1:0] tx_sr;
    logic [WIDTH-1:0] rx_sr;
    logic [WIDTH-1:0] tx_next;
    logic [WIDTH-1:0] rx_next;
    shift_mode_e      tx_mode;
    shift_mode_e      rx_mode;
    logic             busy_d;
    logic             done_d;
    logic             sclk_d;
    logic             cs_n_d;
    logic             mosi_d;

    function automatic logic [WIDTH-1:0] shift_apply(
        input shift_mode_e      mode,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] load,
        input logic             ser_in
    );
        logic [WIDTH-1:0] res;
        case (mode)
            LEFT:    res = {cur[WIDTH-2:0], ser_in};
            RIGHT:   res = {ser_in, cur[WIDTH-1:1]};
            PLOAD:   res = load;
            default: res = cur;
        endcase
        return res;
    endfunction

    // Phase timer runs only inside LEAD/HIGH/LOW and restarts otherwise.
    assign cnt_en    = (state == LEAD) || (state == HIGH) || (state == LOW);
    assign cnt_clear = !cnt_en;

    spi_clkgen #(
        .CLK_DIV(CLK_DIV)
    ) u_clkgen (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (cnt_en),
        .clear     (cnt_clear),
        .phase_tick(phase_tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = LEAD;
                    accept     = 1'b1;
                end
            end
            LEAD: begin
                if (phase_tick) next_state = HIGH;
            end
            HIGH: begin
                if (phase_tick) next_state = LOW;
            end
            LOW: begin
                // bit_cnt counts sclk rises, so it equals WIDTH after the last one.
                if (phase_tick) next_state = (bit_cnt == BCW'(WIDTH)) ? DONE : HIGH;
            end
            DONE: begin
`ifdef SPI_MASTER_BURST_EN
                if (start) begin
                    next_state = LEAD;
                    accept     = 1'b1;
                end else begin
                    next_state = IDLE;
                end
`else
                next_state = IDLE;
`endif
            end
            default: next_state = IDLE;
        endcase
    end

    // Shift control: load on accept, shift tx on entry to LOW, capture miso on entry to HIGH.
    always_comb begin
        tx_mode = HOLD;
        rx_mode = HOLD;
        if (accept) begin
            tx_mode = PLOAD;
        end else if ((state == HIGH) && (next_state == LOW)) begin
            tx_mode = LEFT;
        end
        if ((state != HIGH) && (next_state == HIGH)) begin
            rx_mode = LEFT;
        end
    end

    assign tx_next = shift_apply(tx_mode, tx_sr, tx_data, 1'b0);
    assign rx_next = shift_apply(rx_mode, rx_sr, '0, miso);

    // Output decode from the upcoming state; registered below.
    always_comb begin
        busy_d = (next_state != IDLE);
        done_d = (next_state == DONE);
        sclk_d = (next_state == HIGH);
        mosi_d = 1'b0;
        cs_n_d = 1'b1;
        case (next_state)
            LEAD, HIGH, LOW: begin
                cs_n_d = 1'b0;
                mosi_d = tx_next[WIDTH-1];
            end
            DONE: begin
`ifdef SPI_MASTER_BURST_EN
                // Held low so a chained transfer sees no chip-select glitch.
                cs_n_d = 1'b0;
`else
                cs_n_d = 1'b1;
`endif
            end
            default: begin
                cs_n_d = 1'b1;
            end
        endcase
    end

    // Shift registers and bit counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
        end else begin
            tx_sr <= tx_next;
            rx_sr <= rx_next;
            if (accept) begin
                bit_cnt <= '0;
            end else if (rx_mode == LEFT) begin
                bit_cnt <= bit_cnt + BCW'(1);
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            sclk    <= 1'b0;
            cs_n    <= 1'b1;
            mosi    <= 1'b0;
            rx_data <= '0;
        end else begin
            busy <= busy_d;
            done <= done_d;
            sclk <= sclk_d;
            cs_n <= cs_n_d;
            mosi <= mosi_d;
            if (done_d) begin
                rx_data <= rx_sr;
            end
        end
    end

endmodule
